// File: rtl/temp_sensor_reader.sv
// SPI mode-0 reader for a 13-bit two's-complement temperature sensor.
// Publishes whole degrees in 9-bit sign-magnitude form on temperatura.
module temp_sensor_reader #(
   parameter int CLK_DIV       = 25,
   parameter int SAMPLE_PERIOD = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_miso,
   output logic       spi_sck,
   output logic       spi_cs_n,
   output logic [8:0] temperatura,
   output logic       valid,
   output logic       sensor_err,
   output logic       busy
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int PER_W = $clog2(SAMPLE_PERIOD);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CS_SETUP = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_CS_HOLD  = 2'd3
   } state_t;

   state_t           state_r, state_s;
   logic [DIV_W-1:0] div_r, div_s;
   logic [3:0]       bit_cnt_r, bit_cnt_s;
   logic             sck_r, sck_s;
   logic             cs_n_r, cs_n_s;
   logic             busy_r;
   logic [15:0]      shift_r, shift_s;
   logic [8:0]       temp_r, temp_s;
   logic             valid_r, valid_s;
   logic             err_r, err_s;
   logic [PER_W-1:0] per_cnt_r;
   logic             start_s;
   logic             div_done_s;

   // Whole degrees, truncated toward zero and saturated at 255; never negative zero.
   function automatic logic [8:0] to_sign_mag(input logic [12:0] t);
      logic [12:0] abs_v;
      logic [12:0] deg_v;
      logic [7:0]  mag_v;
      abs_v = t[12] ? (~t + 13'd1) : t;
      deg_v = abs_v >> 4;
      if (deg_v > 13'd255) begin
         mag_v = 8'hFF;
      end else begin
         mag_v = deg_v[7:0];
      end
      return {t[12] && (mag_v != 8'd0), mag_v};
   endfunction

   assign start_s    = (per_cnt_r == PER_LAST);
   assign div_done_s = (div_r == DIV_LAST);

   // Free-running sample period counter, independent of the transaction FSM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         per_cnt_r <= {PER_W{1'b0}};
      end else if (start_s) begin
         per_cnt_r <= {PER_W{1'b0}};
      end else begin
         per_cnt_r <= per_cnt_r + PER_W'(1'b1);
      end
   end

   // Next-state, SPI timing and result commit.
   always_comb begin
      state_s   = state_r;
      div_s     = div_r;
      bit_cnt_s = bit_cnt_r;
      sck_s     = sck_r;
      cs_n_s    = cs_n_r;
      shift_s   = shift_r;
      temp_s    = temp_r;
      valid_s   = 1'b0;
      err_s     = err_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_CS_SETUP;
               cs_n_s  = 1'b0;
               div_s   = {DIV_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CS_SETUP: begin
            if (div_done_s) begin
               state_s   = ST_SHIFT;
               div_s     = {DIV_W{1'b0}};
               bit_cnt_s = 4'd0;
            end else begin
               div_s = div_r + DIV_W'(1'b1);
            end
         end
         ST_SHIFT: begin
            if (!div_done_s) begin
               div_s = div_r + DIV_W'(1'b1);
            end else begin
               div_s = {DIV_W{1'b0}};
               // Sample on the edge that raises sck; data was set up after the prior fall.
               if (!sck_r) begin
                  sck_s   = 1'b1;
                  shift_s = {shift_r[14:0], spi_miso};
               end else begin
                  sck_s = 1'b0;
                  if (bit_cnt_r == 4'd15) begin
                     state_s = ST_CS_HOLD;
                  end else begin
                     bit_cnt_s = bit_cnt_r + 4'd1;
                  end
               end
            end
         end
         ST_CS_HOLD: begin
            if (div_done_s) begin
               state_s = ST_IDLE;
               cs_n_s  = 1'b1;
               div_s   = {DIV_W{1'b0}};
               if (shift_r == 16'hFFFF) begin
                  err_s = 1'b1;
               end else begin
                  temp_s  = to_sign_mag(shift_r[15:3]);
                  valid_s = 1'b1;
                  err_s   = 1'b0;
               end
            end else begin
               div_s = div_r + DIV_W'(1'b1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            cs_n_s  = 1'b1;
            sck_s   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         div_r     <= {DIV_W{1'b0}};
         bit_cnt_r <= 4'd0;
         sck_r     <= 1'b0;
         cs_n_r    <= 1'b1;
         busy_r    <= 1'b0;
         shift_r   <= 16'h0000;
         temp_r    <= 9'h000;
         valid_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         div_r     <= div_s;
         bit_cnt_r <= bit_cnt_s;
         sck_r     <= sck_s;
         cs_n_r    <= cs_n_s;
         busy_r    <= ~cs_n_s;
         shift_r   <= shift_s;
         temp_r    <= temp_s;
         valid_r   <= valid_s;
         err_r     <= err_s;
      end
   end

   assign spi_sck     = sck_r;
   assign spi_cs_n    = cs_n_r;
   assign busy        = busy_r;
   assign temperatura = temp_r;
   assign valid       = valid_r;
   assign sensor_err  = err_r;

   temp_sensor_reader_chk #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD)
   ) u_chk (
      .clk (clk)
   );

endmodule

// Parameter legality check: a transaction must fit inside one sample period.
module temp_sensor_reader_chk #(
   parameter int CLK_DIV       = 25,
   parameter int SAMPLE_PERIOD = 5000000
) (
   input logic clk
);

   // Flag an illegal divider / period combination during simulation.
   always @(posedge clk) begin
      assert (CLK_DIV >= 1 && SAMPLE_PERIOD > 34 * CLK_DIV + 2)
         else $error("temp_sensor_reader: illegal CLK_DIV/SAMPLE_PERIOD");
   end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: sensor model on SPI, directed and random frames
// checked against an arithmetic reference of the conversion and the frame timing.
module tb_temp_sensor_reader;

   localparam int CD   = 2;
   localparam int SP   = 100;
   localparam int XFER = 34 * CD;

   logic       clk;
   logic       rst;
   logic       spi_miso;
   logic       spi_sck;
   logic       spi_cs_n;
   logic [8:0] temperatura;
   logic       valid;
   logic       sensor_err;
   logic       busy;

   logic [15:0] sensor_frame = 16'h0000;
   logic [4:0]  fall_cnt     = 5'd0;
   int          cyc          = 0;
   int          checks       = 0;
   int          failures     = 0;
   int          exp_start    = 0;
   logic [8:0]  model_temp   = 9'h000;
   logic        model_err    = 1'b0;

   temp_sensor_reader #(
      .CLK_DIV       (CD),
      .SAMPLE_PERIOD (SP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_miso    (spi_miso),
      .spi_sck     (spi_sck),
      .spi_cs_n    (spi_cs_n),
      .temperatura (temperatura),
      .valid       (valid),
      .sensor_err  (sensor_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sensor: MSB presented at chip-select fall, next bit after each sck fall.
   always @(negedge spi_sck or posedge spi_cs_n) begin
      if (spi_cs_n === 1'b1) fall_cnt = 5'd0;
      else                   fall_cnt = fall_cnt + 5'd1;
   end
   assign spi_miso = fall_cnt[4] ? 1'b1 : sensor_frame[4'd15 - fall_cnt[3:0]];

   // Reference: signed 1/16 degC reading to whole degrees, toward zero, saturated.
   function automatic logic [8:0] ref_temp(input logic [15:0] f);
      int t;
      int deg;
      int mag;
      t = int'(f) / 8;
      if (t >= 4096) t = t - 8192;
      deg = t / 16;
      mag = (deg < 0) ? -deg : deg;
      if (mag > 255) mag = 255;
      return {deg < 0, 8'(mag)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   // One complete sensor transaction with timing, result and flag checks.
   task automatic run_frame(input logic [15:0] f);
      int         waited;
      int         cs0;
      int         low_cnt;
      int         rises;
      int         vcnt;
      int         vcyc;
      int         busy_bad;
      int         hold_bad;
      logic       sck_prev;
      logic [8:0] vtemp;
      logic       good;
      sensor_frame = f;
      waited = 0;
      while (spi_cs_n === 1'b1 && waited < 3 * SP) begin
         @(negedge clk);
         waited++;
      end
      chk("cs_fall", {31'd0, spi_cs_n}, 32'd0);
      if (spi_cs_n !== 1'b0) return;
      cs0 = cyc;
      chk("start_cycle", cs0, exp_start);
      exp_start = cs0 + SP;
      low_cnt = 0; rises = 0; vcnt = 0; vcyc = -1; busy_bad = 0; hold_bad = 0;
      sck_prev = 1'b0; vtemp = 9'h000;
      for (int i = 0; i < XFER + 12; i++) begin
         if (spi_cs_n === 1'b0) low_cnt++;
         if (!sck_prev && spi_sck === 1'b1) rises++;
         sck_prev = spi_sck;
         if (busy !== ~spi_cs_n) busy_bad++;
         if (valid === 1'b1) begin
            vcnt++;
            vcyc  = cyc;
            vtemp = temperatura;
         end else if (vcnt == 0 && temperatura !== model_temp) begin
            hold_bad++;
         end
         @(negedge clk);
      end
      good = (f != 16'hFFFF);
      if (good) begin
         model_temp = ref_temp(f);
         model_err  = 1'b0;
      end else begin
         model_err  = 1'b1;
      end
      chk("cs_low_cycles", low_cnt, XFER);
      chk("sck_rises", rises, 16);
      chk("busy_tracks_cs", busy_bad, 0);
      chk("temp_held", hold_bad, 0);
      chk("valid_count", vcnt, good ? 1 : 0);
      if (good) begin
         chk("latency", vcyc - cs0 + 1, XFER + 1);
         chk("valid_temp", {23'd0, vtemp}, {23'd0, model_temp});
      end
      chk("temperatura", {23'd0, temperatura}, {23'd0, model_temp});
      chk("sensor_err", {31'd0, sensor_err}, {31'd0, model_err});
   endtask

   initial begin
      int   waited;
      int   rises;
      logic sck_prev;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("rst_sck", {31'd0, spi_sck}, 32'd0);
      chk("rst_temp", {23'd0, temperatura}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_err", {31'd0, sensor_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      exp_start = cyc + SP;

      run_frame(16'h0C80);
      chk("dir_25C", {23'd0, temperatura}, 32'h019);
      run_frame(16'hFAC0);
      chk("dir_m10C", {23'd0, temperatura}, 32'h10A);
      run_frame(16'hFFC0);
      chk("dir_neg_zero", {23'd0, temperatura}, 32'h000);
      run_frame(16'h7FF8);
      chk("dir_max", {23'd0, temperatura}, 32'h0FF);
      run_frame(16'h8000);
      chk("dir_sat", {23'd0, temperatura}, 32'h1FF);
      run_frame(16'h0C80);
      run_frame(16'hFFFF);
      chk("err_keeps_temp", {23'd0, temperatura}, 32'h019);
      chk("err_flag", {31'd0, sensor_err}, 32'd1);
      run_frame(16'h0C80);
      chk("err_cleared", {31'd0, sensor_err}, 32'd0);

      for (int k = 0; k < 8; k++) begin
         run_frame(16'($urandom_range(0, 65535)));
      end

      // Abort a frame mid-way through bit 8.
      sensor_frame = 16'h1234;
      waited = 0;
      while (spi_cs_n === 1'b1 && waited < 3 * SP) begin
         @(negedge clk);
         waited++;
      end
      chk("midrst_cs_fall", {31'd0, spi_cs_n}, 32'd0);
      rises = 0; sck_prev = 1'b0; waited = 0;
      while (rises < 9 && waited < 200) begin
         @(negedge clk);
         waited++;
         if (!sck_prev && spi_sck === 1'b1) rises++;
         sck_prev = spi_sck;
      end
      chk("midrst_bit8", rises, 9);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("midrst_sck", {31'd0, spi_sck}, 32'd0);
      chk("midrst_temp", {23'd0, temperatura}, 32'd0);
      chk("midrst_valid", {31'd0, valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      exp_start  = cyc + SP;
      model_temp = 9'h000;
      model_err  = 1'b0;
      run_frame(16'h0C80);
      chk("after_rst_temp", {23'd0, temperatura}, 32'h019);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/temp_sensor_reader.md
Name: temp_sensor_reader

Overview:
Producer side of the 9-bit sign-magnitude `temperatura` bus that feeds the per-second sum / per-minute average logic. It periodically reads a 16-bit frame from an SPI (mode 0) digital temperature sensor. It converts the 13-bit two's-complement reading (1/16 °C per LSB) to integer degrees in sign-magnitude form. It holds the result on `temperatura` and pulses `valid` once per completed read.

Parameters:
CLK_DIV, 25, clk cycles per SCK half-period (50 MHz clk -> 1 MHz SCK); legal range >= 1.
SAMPLE_PERIOD, 5000000, clk cycles between transaction starts; must be > 34*CLK_DIV + 2 (simulation assertion).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (rst==0 resets)
spi_miso  input  1  sensor serial data, MSB first, changes after SCK falling edge
spi_sck  output  1  SPI clock, idles low
spi_cs_n  output  1  sensor chip select, active-low
temperatura  output  9  bit8 = sign (1 = negative), [7:0] = magnitude in °C
valid  output  1  one-cycle pulse when `temperatura` updates
sensor_err  output  1  last frame was 16'hFFFF (sensor absent / bus stuck high)
busy  output  1  high while `spi_cs_n` is low

Behaviour:
- Reset (rst==0 at a clk edge), applied on that edge regardless of state:
  - spi_cs_n=1, spi_sck=0, temperatura=0, valid=0, sensor_err=0, busy=0.
  - Period counter=0, bit counter=0, divider=0, state=IDLE.
  - Mid-transaction reset aborts the frame: no valid, no update.
- Period counter:
  - Free-running 0..SAMPLE_PERIOD-1, independent of FSM state.
  - Start event when count == SAMPLE_PERIOD-1; counter then wraps to 0.
  - First transaction therefore starts SAMPLE_PERIOD cycles after reset release.
  - A start event in any state other than IDLE is ignored (unreachable with a legal parameter).
- FSM states: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> IDLE.
  - IDLE: cs_n=1, sck=0. On a start event: cs_n goes low at the next edge (call this cycle S) and the FSM enters CS_SETUP.
  - CS_SETUP: CLK_DIV cycles (S .. S+CLK_DIV-1), sck=0.
  - SHIFT: 16 bits, each bit is CLK_DIV cycles with sck low, then CLK_DIV cycles with sck high.
    - On the edge that drives sck 0->1, spi_miso is shifted into a 16-bit register, MSB first.
    - Spans S+CLK_DIV .. S+33*CLK_DIV-1; sck ends low after the 16th high phase.
  - CS_HOLD: CLK_DIV cycles, sck=0.
  - On edge S+34*CLK_DIV: cs_n=1, FSM returns to IDLE, and the result is committed (below).
- busy = ~spi_cs_n, registered.
- Conversion (combinational on the shifted frame F, committed on edge S+34*CLK_DIV):
  - If F == 16'hFFFF: sensor_err=1; temperatura unchanged; valid stays 0.
  - Otherwise, with T = F[15:3] as a 13-bit signed value:
    - mag = |T| >> 4, i.e. truncation toward zero.
    - If mag > 255, mag = 255 (saturate; only T = -4096 hits this).
    - temperatura = {(T<0) && (mag!=0), mag[7:0]}. There is no negative zero.
    - valid=1 for exactly that one cycle; sensor_err=0.
  - F[2:0] is ignored apart from the all-ones check.
- Latency: start event -> valid = 34*CLK_DIV + 1 cycles (851 at default).
- temperatura is stable between valid pulses. Consumers sampling it at any time see the last good reading.

Test Plan:
- CLK_DIV=2, SAMPLE_PERIOD=100, sensor model returns 16'h0C80 (+25.0 °C):
  - cs_n low for exactly 68 cycles; 16 sck rising edges.
  - valid pulses once, 69 cycles after the start event.
  - temperatura = 9'h019; sensor_err = 0.
- Frame 16'hFAC0 (-10.5 °C) -> temperatura = 9'h10A.
- Frame 16'hFFC0 (-0.5 °C) -> temperatura = 9'h000, sign bit clear.
- Boundaries:
  - Frame 16'h7FF8 -> 9'h0FF.
  - Frame 16'h8000 (-256 °C) -> saturates to 9'h1FF.
- Frame 16'hFFFF after a good 9'h019:
  - sensor_err = 1, no valid pulse, temperatura stays 9'h019.
  - Next frame 16'h0C80 clears sensor_err and pulses valid.
- Assert rst=0 during bit 8 of a frame:
  - Next edge: cs_n=1, sck=0, temperatura=0, no valid.
  - After release, the next start occurs SAMPLE_PERIOD cycles later and completes normally.
